// File: rtl/mem_dma_engine.sv
// Block copy / block fill DMA initiator for the core's word-addressed data memory port.
// One word per two cycles for copy (read then write), one word per cycle for fill.
module mem_dma_engine #(
  parameter int LEN_W = 11
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             mode,
  input  logic [31:0]      src,
  input  logic [31:0]      dst,
  input  logic [LEN_W-1:0] len,
  input  logic [31:0]      fill_val,
  output logic             busy,
  output logic             done,
  output logic [LEN_W-1:0] words_done,
  output logic             mem_we,
  output logic [31:0]      mem_a,
  output logic [31:0]      mem_wd,
  input  logic [31:0]      mem_rd
);

  typedef enum logic [1:0] {S_IDLE, S_RD, S_WR, S_FIN} state_e;

  state_e           state_q, state_d;
  logic [31:0]      src_q, src_d;
  logic [31:0]      dst_q, dst_d;
  logic [31:0]      fill_q, fill_d;
  logic [31:0]      buf_q, buf_d;
  logic [LEN_W-1:0] rem_q, rem_d;
  logic [LEN_W-1:0] words_q, words_d;
  logic             mode_q, mode_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      src_q   <= '0;
      dst_q   <= '0;
      fill_q  <= '0;
      buf_q   <= '0;
      rem_q   <= '0;
      words_q <= '0;
      mode_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      src_q   <= src_d;
      dst_q   <= dst_d;
      fill_q  <= fill_d;
      buf_q   <= buf_d;
      rem_q   <= rem_d;
      words_q <= words_d;
      mode_q  <= mode_d;
    end
  end

  // Memory-side outputs decode only from registered state, never from the request inputs.
  always_comb begin
    state_d = state_q;
    src_d   = src_q;
    dst_d   = dst_q;
    fill_d  = fill_q;
    buf_d   = buf_q;
    rem_d   = rem_q;
    words_d = words_q;
    mode_d  = mode_q;
    busy    = 1'b0;
    done    = 1'b0;
    mem_we  = 1'b0;
    mem_a   = '0;
    mem_wd  = '0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          src_d   = src & ~32'h3;
          dst_d   = dst & ~32'h3;
          rem_d   = len;
          mode_d  = mode;
          fill_d  = fill_val;
          words_d = '0;
          if (len == '0)  state_d = S_FIN;
          else if (mode)  state_d = S_WR;
          else            state_d = S_RD;
        end
      end
      S_RD: begin
        busy    = 1'b1;
        mem_a   = src_q;
        buf_d   = mem_rd;
        src_d   = src_q + 32'd4;
        state_d = S_WR;
      end
      S_WR: begin
        busy    = 1'b1;
        mem_a   = dst_q;
        mem_we  = 1'b1;
        mem_wd  = mode_q ? fill_q : buf_q;
        dst_d   = dst_q + 32'd4;
        words_d = words_q + 1'b1;
        rem_d   = rem_q - 1'b1;
        if (rem_q == LEN_W'(1)) state_d = S_FIN;
        else if (mode_q)        state_d = S_WR;
        else                    state_d = S_RD;
      end
      S_FIN: begin
        busy    = 1'b1;
        done    = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign words_done = words_q;

endmodule

// File: tb/tb_mem_dma_engine.sv
// Directed bench for mem_dma_engine with a 4 KB word memory model behind the port.
module tb_mem_dma_engine;

  localparam int LEN_W = 11;

  logic             clk = 1'b0;
  logic             rst;
  logic             start, mode;
  logic [31:0]      src, dst, fill_val;
  logic [LEN_W-1:0] len;
  logic             busy, done, mem_we;
  logic [LEN_W-1:0] words_done;
  logic [31:0]      mem_a, mem_wd, mem_rd;

  logic [31:0] mem [0:1023];
  logic        poke_en = 1'b0;
  logic [9:0]  poke_idx = '0;
  logic [31:0] poke_val = '0;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  mem_dma_engine #(.LEN_W(LEN_W)) dut (
    .clk(clk), .rst(rst), .start(start), .mode(mode), .src(src), .dst(dst),
    .len(len), .fill_val(fill_val), .busy(busy), .done(done),
    .words_done(words_done), .mem_we(mem_we), .mem_a(mem_a), .mem_wd(mem_wd),
    .mem_rd(mem_rd)
  );

  assign mem_rd = mem[mem_a[11:2]];

  always @(posedge clk) begin
    if (mem_we)       mem[mem_a[11:2]] <= mem_wd;
    else if (poke_en) mem[poke_idx]    <= poke_val;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic poke(input int idx, input logic [31:0] val);
    @(negedge clk);
    poke_en = 1'b1; poke_idx = 10'(idx); poke_val = val;
    @(posedge clk);
    #1 poke_en = 1'b0;
  endtask

  // Present a request for one cycle, then scramble the inputs to prove they were latched.
  task automatic go(input logic m, input logic [31:0] s, input logic [31:0] d,
                    input int n, input logic [31:0] f);
    @(negedge clk);
    start = 1'b1; mode = m; src = s; dst = d; len = LEN_W'(n); fill_val = f;
    @(posedge clk);
    #1;
    start = 1'b0; mode = ~m; src = 32'hFFFF_FFF0; dst = 32'hFFFF_FFF0;
    len = LEN_W'(7); fill_val = 32'h0BAD_0BAD;
  endtask

  task automatic wait_done(input int maxc, output int cyc, output int wes);
    cyc = 0; wes = 0;
    forever begin
      @(negedge clk);
      cyc++;
      if (mem_we) wes++;
      if (done) break;
      if (cyc >= maxc) begin
        chk("done_timeout", {31'b0, done}, 32'h1);
        break;
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int cyc, wes, nd, nw;
    rst = 1'b1; start = 1'b0; mode = 1'b0; src = '0; dst = '0; len = '0; fill_val = '0;
    #12;
    chk("rst_busy", {31'b0, busy}, 32'h0);
    chk("rst_done", {31'b0, done}, 32'h0);
    chk("rst_words", 32'(words_done), 32'h0);
    chk("rst_we", {31'b0, mem_we}, 32'h0);
    chk("rst_a", mem_a, 32'h0);
    chk("rst_wd", mem_wd, 32'h0);
    @(negedge clk) rst = 1'b0;

    // Basic copy of four words
    poke(0, 32'h11); poke(1, 32'h22); poke(2, 32'h33); poke(3, 32'h44);
    go(1'b0, 32'h0, 32'h40, 4, 32'h0);
    wait_done(40, cyc, wes);
    chk("copy_cycle", cyc, 9);
    chk("copy_we_cnt", wes, 4);
    chk("copy_words", 32'(words_done), 4);
    chk("copy_m16", mem[16], 32'h11);
    chk("copy_m17", mem[17], 32'h22);
    chk("copy_m18", mem[18], 32'h33);
    chk("copy_m19", mem[19], 32'h44);
    @(negedge clk);
    chk("copy_idle_busy", {31'b0, busy}, 32'h0);
    chk("copy_words_hold", 32'(words_done), 4);

    // Fill of three words, neighbour left alone
    poke(131, 32'h1234_5678);
    go(1'b1, 32'h0, 32'h200, 3, 32'hDEAD_BEEF);
    wait_done(40, cyc, wes);
    chk("fill_cycle", cyc, 4);
    chk("fill_we_cnt", wes, 3);
    chk("fill_words", 32'(words_done), 3);
    chk("fill_m128", mem[128], 32'hDEAD_BEEF);
    chk("fill_m129", mem[129], 32'hDEAD_BEEF);
    chk("fill_m130", mem[130], 32'hDEAD_BEEF);
    chk("fill_m131", mem[131], 32'h1234_5678);

    // Zero-length transfer
    go(1'b1, 32'h0, 32'h80, 0, 32'hFFFF_FFFF);
    wait_done(10, cyc, wes);
    chk("len0_cycle", cyc, 1);
    chk("len0_we_cnt", wes, 0);
    chk("len0_words", 32'(words_done), 0);

    // Unaligned addresses are truncated to word boundaries
    poke(1, 32'h0);
    go(1'b0, 32'h3, 32'h7, 1, 32'h0);
    wait_done(10, cyc, wes);
    chk("unal_cycle", cyc, 3);
    chk("unal_m1", mem[1], 32'h11);

    // Overlapping ascending copy propagates the first word
    poke(0, 32'hA5); poke(1, 32'h0); poke(2, 32'h0); poke(3, 32'h0);
    go(1'b0, 32'h0, 32'h4, 3, 32'h0);
    wait_done(20, cyc, wes);
    chk("ovl_cycle", cyc, 7);
    chk("ovl_m1", mem[1], 32'hA5);
    chk("ovl_m2", mem[2], 32'hA5);
    chk("ovl_m3", mem[3], 32'hA5);

    // Fill wrapping past the top of the address space
    poke(1022, 32'h0);
    go(1'b1, 32'h0, 32'hFFC, 2, 32'hCAFE_F00D);
    wait_done(10, cyc, wes);
    chk("wrap_m1023", mem[1023], 32'hCAFE_F00D);
    chk("wrap_m0", mem[0], 32'hCAFE_F00D);
    chk("wrap_m1", mem[1], 32'hA5);
    chk("wrap_m1022", mem[1022], 32'h0);

    // Start pulse during an active fill is ignored
    poke(192, 32'h0); poke(193, 32'h0); poke(194, 32'h0);
    go(1'b1, 32'h0, 32'h300, 2, 32'h5555_AAAA);
    nd = 0; nw = 0;
    @(negedge clk);
    nd += int'(done); nw += int'(mem_we);
    start = 1'b1; mode = 1'b0; src = 32'h0; dst = 32'h340; len = LEN_W'(5);
    @(posedge clk);
    #1 start = 1'b0;
    repeat (12) begin
      @(negedge clk);
      nd += int'(done); nw += int'(mem_we);
    end
    chk("busy_done_cnt", nd, 1);
    chk("busy_we_cnt", nw, 2);
    chk("busy_words", 32'(words_done), 2);
    chk("busy_m192", mem[192], 32'h5555_AAAA);
    chk("busy_m193", mem[193], 32'h5555_AAAA);
    chk("busy_m194", mem[194], 32'h0);

    // Reset in the second write cycle of a copy abandons the transfer
    poke(0, 32'h77); poke(1, 32'h88); poke(64, 32'h0); poke(65, 32'h0);
    go(1'b0, 32'h0, 32'h100, 4, 32'h0);
    repeat (4) @(negedge clk);
    chk("mid_we_before", {31'b0, mem_we}, 32'h1);
    chk("mid_words_before", 32'(words_done), 1);
    rst = 1'b1;
    #1;
    chk("mid_busy", {31'b0, busy}, 32'h0);
    chk("mid_we", {31'b0, mem_we}, 32'h0);
    chk("mid_words", 32'(words_done), 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    nd = 0;
    repeat (12) begin
      @(negedge clk);
      nd += int'(done);
    end
    chk("mid_no_done", nd, 0);
    chk("mid_m64", mem[64], 32'h77);
    chk("mid_m65", mem[65], 32'h0);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
